// File: rtl/nbn_block_multiplier.sv
// nbn_block_multiplier: N x N single-precision matrix multiplier (N = 2*N_BLK).
// Computes C = A x B, or C = A x B + C_prev when acc_en is set at capture.
// One 2x2 block multiplier and one 2x2 block adder are time-multiplexed over
// all block products, with loop order bi (outer), bj, k (inner).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   A_stb, B_stb          operand strobes; both must be high in IDLE to start
//   acc_en                accumulate into the previous result (sampled at capture)
//   A, B                  packed matrices, element (r,c) at [((r*N+c)*32)+:32]
//   result_ack            consumer accepts result
//   result_ready, busy    handshake / status
//   result                packed matrix C, held until the next DONE or reset
module nbn_block_multiplier #(
  parameter int unsigned N_BLK = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       A_stb,
  input  logic                       B_stb,
  input  logic                       acc_en,
  input  logic [32*4*N_BLK*N_BLK-1:0] A,
  input  logic [32*4*N_BLK*N_BLK-1:0] B,
  input  logic                       result_ack,
  output logic                       result_ready,
  output logic                       busy,
  output logic [32*4*N_BLK*N_BLK-1:0] result
);

  localparam int unsigned N = 2 * N_BLK;
  localparam int unsigned W = 32 * N * N;
  localparam logic [3:0]  KLast = 4'(N_BLK - 1);

  typedef enum logic [2:0] {
    StIdle, StLoadMult, StWaitMult, StLoadAdd, StWaitAdd, StNext, StDone
  } state_e;

  // Single-precision multiply, round-to-nearest-even. Denormal inputs act as zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic              s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, g, st;
    logic [47:0]       prod;
    logic signed [9:0] e;
    logic [22:0]       frac;
    logic [23:0]       rnd;
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hff) && (x[22:0] != '0);
    y_nan  = (y[30:23] == 8'hff) && (y[22:0] != '0);
    x_inf  = (x[30:23] == 8'hff) && (x[22:0] == '0);
    y_inf  = (y[30:23] == 8'hff) && (y[22:0] == '0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) return 32'h7fc0_0000;
    if (x_inf || y_inf) return {s, 8'hff, 23'h0};
    if (x_zero || y_zero) return {s, 31'h0};
    prod = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e    = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
    if (prod[47]) begin
      frac = prod[46:24];
      g    = prod[23];
      st   = |prod[22:0];
      e    = e + 10'sd1;
    end else begin
      frac = prod[45:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    rnd = {1'b0, frac} + {23'h0, g && (st || frac[0])};
    if (rnd[23]) e = e + 10'sd1;
    if (e >= 10'sd255) return {s, 8'hff, 23'h0};
    if (e <= 10'sd0) return {s, 31'h0};
    return {s, e[7:0], rnd[22:0]};
  endfunction

  // Single-precision add, round-to-nearest-even. Denormal inputs act as zero.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic              x_nan, y_nan, x_inf, y_inf, found;
    logic [31:0]       big, sml;
    logic [26:0]       bm, sm, m;
    logic [49:0]       sh;
    logic [7:0]        d;
    logic [5:0]        dd;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [24:0]       rnd;
    logic signed [9:0] e;
    x_nan = (x[30:23] == 8'hff) && (x[22:0] != '0);
    y_nan = (y[30:23] == 8'hff) && (y[22:0] != '0);
    x_inf = (x[30:23] == 8'hff) && (x[22:0] == '0);
    y_inf = (y[30:23] == 8'hff) && (y[22:0] == '0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) return 32'h7fc0_0000;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x[30:23] == 8'h00) return (y[30:23] == 8'h00) ? {x[31] & y[31], 31'h0} : y;
    if (y[30:23] == 8'h00) return x;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    d  = big[30:23] - sml[30:23];
    dd = (d > 8'd49) ? 6'd49 : d[5:0];
    bm = {1'b1, big[22:0], 3'b0};
    sm = {1'b1, sml[22:0], 3'b0};
    // Align the smaller operand; everything shifted past the round bit folds into sticky.
    sh = {sm, 23'h0} >> dd;
    sm = {sh[49:24], |sh[23:0]};
    e  = $signed({2'b0, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, bm} + {1'b0, sm};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = e + 10'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = bm - sm;
      if (m == '0) return 32'h0;
      lz    = '0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && m[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      m = m << lz;
      e = e - $signed({5'b0, lz});
    end
    rnd = {1'b0, m[26:3]} + {24'h0, m[2] && (m[1] || m[0] || m[3])};
    if (rnd[24]) e = e + 10'sd1;
    if (e >= 10'sd255) return {big[31], 8'hff, 23'h0};
    if (e <= 10'sd0) return {big[31], 31'h0};
    return {big[31], e[7:0], rnd[22:0]};
  endfunction

  // 2x2 blocks are packed {e11, e10, e01, e00}, e(r,c) at [(2r+c)*32 +: 32].
  function automatic logic [127:0] mat2_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        z[(2*r+c)*32 +: 32] = fp_add(fp_mul(x[(2*r)*32 +: 32], y[c*32 +: 32]),
                                     fp_mul(x[(2*r+1)*32 +: 32], y[(2+c)*32 +: 32]));
      end
    end
    return z;
  endfunction

  function automatic logic [127:0] mat2_add(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    for (int i = 0; i < 4; i++) z[i*32 +: 32] = fp_add(x[i*32 +: 32], y[i*32 +: 32]);
    return z;
  endfunction

  function automatic int elem_idx(input logic [3:0] br, input logic [3:0] bc, input int r,
                                  input int c);
    return ((2 * int'(br) + r) * int'(N) + 2 * int'(bc) + c) * 32;
  endfunction

  function automatic logic [127:0] get_blk(input logic [W-1:0] mat, input logic [3:0] br,
                                           input logic [3:0] bc);
    logic [127:0] blk;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) blk[(2*r+c)*32 +: 32] = mat[elem_idx(br, bc, r, c) +: 32];
    end
    return blk;
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] a_q, b_q, c_q, c_d, c_prev_q, result_q;
  logic         acc_en_q, result_ready_q, busy_q;
  logic [3:0]   bi_q, bj_q, k_q;
  logic [127:0] p_q, acc_q;

  // Block unit handshake signals.
  logic         mult_load, mult_ack, mult_rdy_q;
  logic [127:0] mult_op_a, mult_op_b, mult_res_q;
  logic         add_stb, add_ack, add_rdy_q;
  logic [127:0] add_op_a, add_op_b, add_res_q;

  logic last_blk;

  assign last_blk  = (bi_q == KLast) && (bj_q == KLast);
  assign mult_load = (state_q == StLoadMult) || (state_q == StWaitMult);
  assign mult_ack  = (state_q == StWaitMult) && mult_rdy_q;
  assign mult_op_a = get_blk(a_q, bi_q, k_q);
  assign mult_op_b = get_blk(b_q, k_q, bj_q);
  assign add_stb   = (state_q == StLoadAdd) || (state_q == StWaitAdd);
  assign add_ack   = (state_q == StWaitAdd) && add_rdy_q;
  // k == 0 only reaches the adder in accumulate mode: seed with the previous C block.
  assign add_op_a  = (k_q == 4'd0) ? get_blk(c_prev_q, bi_q, bj_q) : acc_q;
  assign add_op_b  = p_q;

  assign result_ready = result_ready_q;
  assign busy         = busy_q;
  assign result       = result_q;

  // 2x2 block multiplier: result ready one cycle after load, cleared by ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_rdy_q <= 1'b0;
      mult_res_q <= '0;
    end else if (mult_ack) begin
      mult_rdy_q <= 1'b0;
    end else if (mult_load && !mult_rdy_q) begin
      mult_res_q <= mat2_mul(mult_op_a, mult_op_b);
      mult_rdy_q <= 1'b1;
    end
  end

  // 2x2 block adder, same handshake as the multiplier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_rdy_q <= 1'b0;
      add_res_q <= '0;
    end else if (add_ack) begin
      add_rdy_q <= 1'b0;
    end else if (add_stb && !add_rdy_q) begin
      add_res_q <= mat2_add(add_op_a, add_op_b);
      add_rdy_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (A_stb && B_stb) state_d = StLoadMult;
      StLoadMult: state_d = StWaitMult;
      StWaitMult: if (mult_rdy_q) state_d = (k_q == 4'd0 && !acc_en_q) ? StNext : StLoadAdd;
      StLoadAdd:  state_d = StWaitAdd;
      StWaitAdd:  if (add_rdy_q) state_d = StNext;
      StNext:     state_d = (k_q == KLast && last_blk) ? StDone : StLoadMult;
      StDone:     if (result_ack) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // C with the finished block merged in, so DONE can publish it on the same edge.
  always_comb begin
    c_d = c_q;
    if (state_q == StNext && k_q == KLast) begin
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) c_d[elem_idx(bi_q, bj_q, r, c) +: 32] = acc_q[(2*r+c)*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      a_q            <= '0;
      b_q            <= '0;
      c_q            <= '0;
      c_prev_q       <= '0;
      result_q       <= '0;
      acc_en_q       <= 1'b0;
      result_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      bi_q           <= '0;
      bj_q           <= '0;
      k_q            <= '0;
      p_q            <= '0;
      acc_q          <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      unique case (state_q)
        StIdle: begin
          if (A_stb && B_stb) begin
            a_q      <= A;
            b_q      <= B;
            acc_en_q <= acc_en;
            busy_q   <= 1'b1;
            bi_q     <= '0;
            bj_q     <= '0;
            k_q      <= '0;
          end
        end
        StWaitMult: begin
          if (mult_rdy_q) begin
            p_q <= mult_res_q;
            if (k_q == 4'd0 && !acc_en_q) acc_q <= mult_res_q;
          end
        end
        StWaitAdd: if (add_rdy_q) acc_q <= add_res_q;
        StNext: begin
          if (k_q != KLast) begin
            k_q <= k_q + 4'd1;
          end else begin
            k_q <= '0;
            if (bj_q != KLast) begin
              bj_q <= bj_q + 4'd1;
            end else begin
              bj_q <= '0;
              bi_q <= bi_q + 4'd1;
            end
            if (last_blk) begin
              result_q       <= c_d;
              c_prev_q       <= c_d;
              result_ready_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (result_ack) begin
            result_ready_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
